// File: rtl/bus_arbiter2_if.sv
// Two-master / one-slave bus bundle for bus_arbiter2.
// slave = arbiter view (serves the masters); master = environment view.
interface bus_arbiter2_if;
    logic [31:0] m0_a, m1_a;
    logic [31:0] m0_d, m1_d;
    logic        m0_rd, m1_rd;
    logic        m0_we, m1_we;
    logic [31:0] m0_spo, m1_spo;
    logic        m0_ready, m1_ready;
    logic [31:0] s_a, s_d;
    logic        s_rd, s_we;
    logic [31:0] s_spo;
    logic        s_ready;
    logic        owner;

    modport slave (
        input  m0_a, m1_a, m0_d, m1_d, m0_rd, m1_rd, m0_we, m1_we, s_spo, s_ready,
        output m0_spo, m1_spo, m0_ready, m1_ready, s_a, s_d, s_rd, s_we, owner
    );

    modport master (
        output m0_a, m1_a, m0_d, m1_d, m0_rd, m1_rd, m0_we, m1_we, s_spo, s_ready,
        input  m0_spo, m1_spo, m0_ready, m1_ready, s_a, s_d, s_rd, s_we, owner
    );
endinterface

// File: rtl/bus_arbiter2.sv
// Two-master arbiter onto one slave: per-master pending slot, IDLE/ISSUE/WAIT
// sequencing, round-robin or fixed m0 priority.
module bus_arbiter2 #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    bus_arbiter2_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            r_state, w_next;
    logic [1:0]        r_pend_v, r_pend_we;
    logic [1:0][31:0]  r_pend_a, r_pend_d;
    logic              r_ptr;
    logic              r_owner;
    logic [31:0]       r_s_a, r_s_d;
    logic              r_s_rd, r_s_we;

    logic [1:0]        w_stb, w_mwe, w_done_x, w_latch;
    logic [1:0][31:0]  w_ma, w_md;
    logic              w_busy, w_done, w_grant_v, w_grant;

    assign w_stb   = {bus.m1_rd | bus.m1_we, bus.m0_rd | bus.m0_we};
    assign w_mwe   = {bus.m1_we, bus.m0_we};
    assign w_ma    = {bus.m1_a, bus.m0_a};
    assign w_md    = {bus.m1_d, bus.m0_d};

    assign w_busy    = (r_state == ISSUE) || (r_state == WAIT);
    assign w_done    = w_busy && bus.s_ready;
    assign w_done_x  = {w_done && r_owner, w_done && !r_owner};
    assign w_grant_v = (r_state == IDLE) && (|r_pend_v);

    // A completing owner frees its slot this cycle, so its strobe may refill it.
    assign w_latch = w_stb & (~r_pend_v | w_done_x);

    always_comb begin
        w_grant = r_pend_v[1];
        if (&r_pend_v)
            w_grant = FIXED_PRIO ? 1'b0 : r_ptr;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_v) w_next = ISSUE;
            ISSUE:   w_next = w_done ? IDLE : WAIT;
            WAIT:    if (w_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pend_v  <= '0;
            r_pend_we <= '0;
            r_pend_a  <= '0;
            r_pend_d  <= '0;
            r_ptr     <= 1'b0;
            r_owner   <= 1'b0;
            r_s_a     <= '0;
            r_s_d     <= '0;
            r_s_rd    <= 1'b0;
            r_s_we    <= 1'b0;
        end else begin
            r_state <= w_next;
            for (int i = 0; i < 2; i++) begin
                if (w_latch[i]) begin
                    r_pend_v[i]  <= 1'b1;
                    r_pend_a[i]  <= w_ma[i];
                    r_pend_d[i]  <= w_md[i];
                    r_pend_we[i] <= w_mwe[i];
                end else if (w_done_x[i]) begin
                    r_pend_v[i]  <= 1'b0;
                end
            end
            // Strobes are set only on the grant edge, giving a single ISSUE-cycle pulse.
            if (w_grant_v) begin
                r_owner <= w_grant;
                r_s_a   <= r_pend_a[w_grant];
                r_s_d   <= r_pend_d[w_grant];
                r_s_rd  <= !r_pend_we[w_grant];
                r_s_we  <= r_pend_we[w_grant];
            end else begin
                r_s_rd  <= 1'b0;
                r_s_we  <= 1'b0;
            end
            if (w_done)
                r_ptr <= !r_owner;
        end
    end

    assign bus.s_a      = r_s_a;
    assign bus.s_d      = r_s_d;
    assign bus.s_rd     = r_s_rd;
    assign bus.s_we     = r_s_we;
    assign bus.owner    = r_owner;
    assign bus.m0_ready = w_done_x[0] || (!r_pend_v[0] && !w_stb[0]);
    assign bus.m1_ready = w_done_x[1] || (!r_pend_v[1] && !w_stb[1]);
    assign bus.m0_spo   = w_done_x[0] ? bus.s_spo : 32'h0;
    assign bus.m1_spo   = w_done_x[1] ? bus.s_spo : 32'h0;
endmodule
